// File: rtl/uart_imem_loader_pkg.sv
// ============================================================================
// uart_imem_loader_pkg : shared state encodings and image-format constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    WORD   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } ld_state_t;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_STOP   = 3'd3,
    R_WAITHI = 3'd4
  } rx_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/uart_imem_loader_rx.sv
// ============================================================================
// uart_rx : 2-flop synchroniser plus 8N1 bit sampler with frame-error flag
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              c_CW   = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1, r_sync2;
  rx_state_t       r_state, w_next;
  logic [c_CW-1:0] r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_half, w_full;

  assign w_half = (r_clk_cnt == c_HALF);
  assign w_full = (r_clk_cnt == c_FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      R_IDLE:   if (!r_sync2) w_next = R_START;
      R_START:  if (w_half) w_next = r_sync2 ? R_IDLE : R_DATA;
      R_DATA:   if (w_full && (r_bit_idx == 3'd7)) w_next = R_STOP;
      R_STOP:   if (w_full) w_next = r_sync2 ? R_IDLE : R_WAITHI;
      R_WAITHI: if (r_sync2) w_next = R_IDLE;
      default:  w_next = R_IDLE;
    endcase
  end

  // Bit timer restarts on every state change so each phase counts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_clk_cnt <= ((r_state != w_next) || w_full) ? '0 : r_clk_cnt + 1'b1;
      if ((r_state == R_DATA) && w_full) begin
        r_shift   <= {r_sync2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    byte_valid = (r_state == R_STOP) && w_full && r_sync2;
    frame_err  = (r_state == R_STOP) && w_full && !r_sync2;
    byte_data  = r_shift;
  end

endmodule

`default_nettype wire

// File: rtl/uart_imem_loader.sv
// ============================================================================
// uart_imem_loader : UART boot loader writing a big-endian word image to IMEM
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_WORDS    = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  bypass,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  logic        w_byte_valid, w_frame_err;
  logic [7:0]  w_byte_data;
  ld_state_t   r_state, w_next;
  logic [15:0] r_cnt, r_words;
  logic [1:0]  r_bidx;
  logic [23:0] r_shreg;
  logic [15:0] w_n, w_words_inc;
  logic [31:0] w_word;
  logic        w_last_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  assign w_n         = {r_cnt[15:8], w_byte_data};
  assign w_word      = {r_shreg, w_byte_data};
  assign w_last_byte = (r_bidx == 2'(WORD_BYTES - 1));
  assign w_words_inc = r_words + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bypass)            w_next = DONE;
        else if (w_byte_valid) w_next = HDR_LO;
      end
      HDR_LO: begin
        if (w_byte_valid) begin
          if (w_n == 16'd0)                        w_next = DONE;
          else if ({1'b0, w_n} > c_MAX_WORDS)      w_next = ERROR;
          else                                     w_next = WORD;
        end
      end
      WORD:    if (w_byte_valid && w_last_byte) w_next = WRITE;
      WRITE:   w_next = (w_words_inc == r_cnt) ? DONE : WORD;
      DONE:    w_next = DONE;
      ERROR:   w_next = ERROR;
      default: w_next = ERROR;
    endcase
    // Once the CPU is running a bad frame must not pull it back into reset.
    if (w_frame_err && (r_state != DONE)) w_next = ERROR;
  end

  always_comb begin
    imem_wren = (r_state == WRITE);
  end

  // Status flags are registered from the next state so they change cleanly on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= 16'd0;
      r_words   <= 16'd0;
      r_bidx    <= 2'd0;
      r_shreg   <= 24'd0;
      imem_addr <= '0;
      imem_data <= 32'd0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_byte_valid) r_cnt[15:8] <= w_byte_data;
        HDR_LO: begin
          if (w_byte_valid) begin
            r_cnt[7:0] <= w_byte_data;
            r_words    <= 16'd0;
            r_bidx     <= 2'd0;
            imem_addr  <= '0;
          end
        end
        WORD: begin
          if (w_byte_valid) begin
            r_shreg <= {r_shreg[15:0], w_byte_data};
            r_bidx  <= r_bidx + 2'd1;
            if (w_last_byte) imem_data <= w_word;
          end
        end
        WRITE: begin
          imem_addr <= imem_addr + 1'b1;
          r_words   <= w_words_inc;
        end
        default: ;
      endcase
      cpu_reset <= (w_next != DONE);
      busy      <= (w_next == HDR_LO) || (w_next == WORD) || (w_next == WRITE);
      done      <= (w_next == DONE);
      if (w_frame_err || (w_next == ERROR)) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
// ============================================================================
// tb_uart_imem_loader : directed + randomized images against a byte-level model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_imem_loader;
  import uart_imem_loader_pkg::*;

  localparam int CPB  = 4;
  localparam int AW   = 12;
  localparam int MAXW = 4096;

  logic          clk = 1'b0;
  logic          rst, rx, bypass;
  logic          imem_wren, cpu_reset, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;

  always #5 clk = ~clk;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock     (clk),
    .reset     (rst),
    .rx        (rx),
    .bypass    (bypass),
    .imem_wren (imem_wren),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int  n_chk = 0;
  int  n_fail = 0;
  wr_t exp_q[$];
  wr_t wr_log[$];
  wr_t mon_e;
  int  cyc = 0;
  int  last_wr_cyc = -1;
  int  fall_cyc = -1;
  logic prev_cpu_rst = 1'b1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every-cycle monitor: invariants plus write scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    check("cpu_reset_is_not_done", 64'(cpu_reset), 64'(!done));
    check("busy_exclusive", 64'(busy & (done | err)), 64'd0);
    if (prev_cpu_rst && !cpu_reset) fall_cyc = cyc;
    prev_cpu_rst = cpu_reset;
    if (imem_wren) begin
      last_wr_cyc = cyc;
      wr_log.push_back(wr_t'{a: imem_addr, d: imem_data});
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none", imem_addr, imem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(mon_e.a));
        check("write_data", 64'(imem_data), 64'(mon_e.d));
      end
    end
  end

  // Byte-stream model: what the loader must write and where it must end up.
  task automatic model(input logic [7:0] b[$], input int bad, output bit d, output bit e, output bit bz);
    int  n;
    bit  got;
    n = -1; d = 0; e = 0; got = 0;
    for (int i = 0; i < b.size(); i++) begin
      if (i == bad) begin
        e = 1;
        if (!d) break;
        continue;
      end
      if (d) continue;
      got = 1;
      if (i == HDR_BYTES - 1) begin
        n = int'({b[0], b[1]});
        if (n == 0) d = 1;
        else if (n > MAXW) begin e = 1; break; end
      end else if (i >= HDR_BYTES) begin
        int k;
        k = i - HDR_BYTES;
        if (k % WORD_BYTES == WORD_BYTES - 1) begin
          exp_q.push_back(wr_t'{a: AW'(k / WORD_BYTES), d: {b[i-3], b[i-2], b[i-1], b[i]}});
          if (k / WORD_BYTES == n - 1) d = 1;
        end
      end
    end
    bz = got && !d && !e;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit good_stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = v[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = good_stop;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk) rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic run_image(input logic [7:0] b[$], input int bad, input bit do_rst, input string tag);
    bit d, e, bz;
    if (do_rst) reset_dut();
    model(b, bad, d, e, bz);
    foreach (b[i]) send_byte(b[i], i != bad);
    repeat (3 * CPB) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_err"}, 64'(err), 64'(e));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!d));
    check({tag, "_busy"}, 64'(busy), 64'(bz));
    check({tag, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b[$];
    int         n, bad;
    rst = 1'b1; rx = 1'b1; bypass = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wren", 64'(imem_wren), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_data", 64'(imem_data), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
    run_image(b, -1, 1'b1, "two_words");
    check("two_words_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() >= 2) begin
      check("two_words_w0", 64'(wr_log[0]), {20'd0, 12'h000, 32'hDEADBEEF});
      check("two_words_w1", 64'(wr_log[1]), {20'd0, 12'h001, 32'h00000013});
    end
    check("two_words_release_latency", 64'(fall_cyc - last_wr_cyc), 64'd1);

    b = '{8'h00, 8'h00};
    run_image(b, -1, 1'b1, "empty");
    check("empty_count", 64'(wr_log.size()), 64'd0);

    b = '{8'h10, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    run_image(b, -1, 1'b1, "oversize");
    check("oversize_count", 64'(wr_log.size()), 64'd0);

    b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_image(b, 7, 1'b1, "frame_mid_word");
    check("frame_mid_word_count", 64'(wr_log.size()), 64'd1);

    reset_dut();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    check("glitch_busy", 64'(busy), 64'd0);
    check("glitch_err", 64'(err), 64'd0);
    b = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_image(b, -1, 1'b0, "after_glitch");

    @(negedge clk) rst = 1'b1;
    bypass = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bypass_cpu_reset", 64'(cpu_reset), 64'd0);
    check("bypass_done", 64'(done), 64'd1);
    @(negedge clk) bypass = 1'b0;

    b = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    run_image(b, -1, 1'b1, "partial");
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_image(b, -1, 1'b1, "reload");
    check("reload_count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1) check("reload_word", 64'(wr_log[0]), {20'd0, 12'h000, 32'h12345678});

    b = '{8'h00, 8'h00, 8'h5A};
    run_image(b, 2, 1'b1, "frame_in_done");

    for (int it = 0; it < 24; it++) begin
      b.delete();
      n = (it % 6 == 5) ? int'($urandom_range(4097, 65535)) : int'($urandom_range(1, 4));
      b.push_back(8'(n >> 8));
      b.push_back(8'(n));
      for (int j = 0; j < WORD_BYTES * ((n > 4) ? 1 : n); j++) b.push_back(8'($urandom));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, b.size() - 1)) : -1;
      run_image(b, bad, 1'b1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Serial boot loader that sits directly upstream of the instruction memory.
- Receives a program image over a UART RX line and assembles big-endian 32-bit words.
- Writes the words sequentially into instruction memory through a write port.
- Holds the processor in reset until the image is complete, then releases it.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- ADDR_WIDTH, 12, instruction memory word-address width.
- MAX_WORDS, 4096, largest accepted image in words; must be <= 2**ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input, idle high, asynchronous to clock.
- bypass  in  1  sampled in IDLE; if 1, skip loading and go to DONE.
- imem_wren  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_data  out  32  word to write.
- cpu_reset  out  1  reset for the processor; 1 until the load completes.
- busy  out  1  load in progress (a header or word byte has been received).
- done  out  1  image fully written; sticky until reset.
- err  out  1  frame or size error; sticky until reset.

Behaviour:
- Reset values (async, reset=1):
  - imem_wren=0, imem_addr=0, imem_data=0.
  - cpu_reset=1, busy=0, done=0, err=0.
  - FSM=IDLE, RX FSM=R_IDLE.
- RX front end:
  - rx passes through a 2-flop synchroniser reset to 1.
  - A start bit is a synchronised 0 seen in R_IDLE.
  - Wait CLKS_PER_BIT/2 cycles and re-check: if the line is 1, it is a glitch; return to R_IDLE.
  - Then sample every CLKS_PER_BIT cycles: 8 data bits, LSB first, then the stop bit.
  - Stop bit = 1: assert byte_valid for one cycle with the byte.
  - Stop bit = 0: set err, drop the byte, wait for the line to return high, then return to R_IDLE.
  - No parity bit.
- Image format:
  - Header: 2 bytes, word count N, big-endian.
  - Then N words of 4 bytes each, most significant byte first.
- Loader FSM states: IDLE, HDR_LO, WORD, WRITE, DONE, ERROR.
  - IDLE:
    - bypass=1 -> DONE.
    - Otherwise, first byte_valid -> cnt[15:8]=byte, busy=1 -> HDR_LO.
  - HDR_LO, on byte_valid, cnt[7:0]=byte, then:
    - N=0 -> DONE.
    - N>MAX_WORDS -> ERROR.
    - Otherwise -> WORD with byte index 0 and imem_addr=0.
  - WORD:
    - Each byte_valid shifts into the word: shreg = {shreg[23:0], byte}.
    - On the 4th byte: imem_data=word -> WRITE.
  - WRITE:
    - imem_wren=1 for exactly this one cycle.
    - On exit, imem_addr increments and the word counter increments.
    - Counter reaches N -> DONE; otherwise -> WORD.
  - DONE: cpu_reset=0, busy=0, done=1. Further RX bytes are ignored.
  - ERROR: cpu_reset stays 1, busy=0, err=1. Only reset exits ERROR.
- Frame errors:
  - A frame error in any state except DONE forces ERROR.
  - In DONE, a frame error sets err only; the CPU keeps running.
- Timing:
  - A WRITE always completes before the next byte_valid can arrive (≥10*CLKS_PER_BIT cycles apart), so no overrun is possible.
  - imem_addr and imem_data are stable during the imem_wren cycle.
  - cpu_reset deasserts the cycle after the final WRITE, registered and glitch-free.
- Reset mid-load:
  - All state clears; the partial image remains in memory.
  - The loader waits for a fresh header.
- imem_addr never wraps, because N<=MAX_WORDS.

Decomposition:
- Shared package holds:
  - the loader state enum (IDLE..ERROR);
  - the RX state enum (R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI);
  - HDR_BYTES=2 and WORD_BYTES=4 constants.
- One natural sub-module: uart_rx (synchroniser plus bit sampler), producing byte_valid, byte_data and frame_err.

Test Plan (CLKS_PER_BIT=4 for simulation):
- Send header 00 02, then words DE AD BE EF and 00 00 00 13.
  - Two imem_wren pulses: (addr 0, 0xDEADBEEF) and (addr 1, 0x00000013).
  - cpu_reset falls one cycle after the second pulse; done=1.
- Header 00 00 -> no imem_wren; done=1 and cpu_reset=0 on the cycle after the second header byte.
- Header 10 01 (N=4097) -> ERROR: err=1, cpu_reset=1, no writes. Later bytes are ignored until reset.
- Byte with stop bit 0 during a word -> err=1, ERROR, no write for that word, cpu_reset stays 1.
- Hold rx low for only 1 cycle while idle (glitch) -> no byte_valid and no state change.
- bypass=1 after reset -> DONE within 2 cycles with cpu_reset=0.
- Reset mid-load: assert reset after the 3rd word byte, then resend a full 1-word image.
  - Exactly one write at addr 0 with the new word; done=1.
